lc4_multiplier_seq: RTL
=======================

// Module: lc4_multiplier_seq
// PURPOSE
//  Iterative unsigned WIDTH x WIDTH shift-add multiplier; inverse operation of the LC4 divider.
//  Retires one multiplier bit per clock and returns a 2*WIDTH-bit product.
//  Serves as the MUL unit of the LC4 ALU.
//  Paired with the divider in the bench: quotient*divisor + remainder == dividend.
// PARAMETERS
//  WIDTH  16  operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
// PORTS
//  clk             in   1      single clock, all state updates on posedge
//  rst             in   1      asynchronous, active-high reset
//  i_start         in   1      request; sampled only when o_busy==0
//  i_multiplicand  in   WIDTH  operand A, captured on accepted i_start
//  i_multiplier    in   WIDTH  operand B, captured on accepted i_start
//  o_busy          out  1      1 while in RUN; i_start ignored
//  o_valid         out  1      one-cycle pulse: o_product_* holds a new result
//  o_product_lo    out  WIDTH  product[WIDTH-1:0], LC4 MUL result
//  o_product_hi    out  WIDTH  product[2*WIDTH-1:WIDTH]
//  o_overflow      out  1      1 when o_product_hi != 0; held with the product
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
//  Reset (async, immediate):
//   - state=IDLE; o_busy=0, o_valid=0, o_product_lo/hi=0, o_overflow=0.
//   - Counter and operand registers are cleared.
//   - Reset in RUN aborts the operation; no o_valid follows it.
//  States:
//   - IDLE: start=1 -> RUN; capture A and B; acc=0; count=0.
//   - RUN: one iteration per edge.
//       If B[0]==1, then acc_hi = acc_hi + A (WIDTH+1-bit add, carry kept).
//       Then {carry,acc_hi,B} shifts right by 1.
//       count increments by 1.
//     At the edge where count reaches WIDTH-1 -> DONE.
//     On that edge, load o_product_hi/lo and o_overflow; set o_valid=1.
//   - DONE: o_valid=1 for exactly this cycle. Products stay stable.
//       start=1 -> RUN (back-to-back, new operands captured); else -> IDLE.
//  Latency:
//   - i_start accepted at edge E.
//   - o_busy=1 during the WIDTH cycles after E.
//   - o_valid=1 during the cycle after edge E+WIDTH.
//   - Next start accepted at edge E+WIDTH+1 at earliest.
//   - Latency is fixed; there is no early-out for zero or small operands.
//  Handshake:
//   - i_start while o_busy=1 is ignored and not queued.
//   - Operand changes after capture have no effect.
//   - No backpressure: the consumer must sample when o_valid=1.
//  Output hold:
//   - o_product_* and o_overflow change only on the result-load edge or on reset.
//   - They hold the last result through IDLE and through the next RUN.
//  Arithmetic:
//   - Unsigned only.
//   - The adder carry-out is shifted into acc MSB and never lost.
//   - All-ones x all-ones must be exact.
//  o_busy and o_valid are never 1 in the same cycle.
// TESTING
//  T1 basic (WIDTH=16):
//     A=0x0003, B=0x0005, start 1 cycle
//     -> o_valid after exactly 16 busy cycles; lo=0x000F, hi=0, ovf=0.
//  T2 max:
//     A=B=0xFFFF
//     -> hi=0xFFFE, lo=0x0001, ovf=1.
//     A=0x0100, B=0x0100 -> hi=0x0001, lo=0x0000, ovf=1.
//  T3 zero and latency:
//     A=0x0000, B=0xBEEF -> product 0, ovf=0, still 16 busy cycles.
//     A=0xBEEF, B=0x0001 -> lo=0xBEEF.
//  T4 handshake:
//     start held high continuously -> results spaced 17 cycles apart.
//     Operands changed mid-RUN -> result uses the captured values.
//     start pulses during RUN -> ignored.
//  T5 reset:
//     assert rst asynchronously (between edges) at iteration 7
//     -> all outputs 0 immediately; no o_valid follows.
//     A new start after release -> correct product.
//  T6 divider cross-check:
//     random and corner dividend/divisor through lc4_divider (divisor!=0).
//     Multiply quotient*divisor, then add remainder
//     -> equals dividend, with hi=0 for the product.

Source files
------------

// File: rtl/lc4_multiplier_seq_if.sv
// lc4_multiplier_seq_if
//   Request/result bundle for the iterative LC4 multiplier.
//   master: the requester (drives i_start and operands, reads results).
//   slave : the multiplier itself.
// Signals
//   i_start         request, honoured only while o_busy==0
//   i_multiplicand  operand A, captured when a request is accepted
//   i_multiplier    operand B, captured when a request is accepted
//   o_busy          1 while iterating; requests are ignored
//   o_valid         one-cycle pulse: o_product_* carries a new result
//   o_product_lo    low half of the product (LC4 MUL result)
//   o_product_hi    high half of the product
//   o_overflow      1 when o_product_hi != 0, held with the product
//   dbg_state       current FSM state, for observation only
// Handshake: a request is accepted on the rising edge where i_start==1 and
// o_busy==0; there is no backpressure, so the consumer must take the result
// in the single cycle o_valid==1 (the product registers keep it afterwards).
interface lc4_multiplier_seq_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [WIDTH-1:0] i_multiplicand;
    logic [WIDTH-1:0] i_multiplier;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_product_lo;
    logic [WIDTH-1:0] o_product_hi;
    logic             o_overflow;
    logic [1:0]       dbg_state;

    modport master (
        output i_start,
        output i_multiplicand,
        output i_multiplier,
        input  o_busy,
        input  o_valid,
        input  o_product_lo,
        input  o_product_hi,
        input  o_overflow,
        input  dbg_state
    );

    modport slave (
        input  i_start,
        input  i_multiplicand,
        input  i_multiplier,
        output o_busy,
        output o_valid,
        output o_product_lo,
        output o_product_hi,
        output o_overflow,
        output dbg_state
    );
endinterface

// File: rtl/lc4_multiplier_seq.sv
// lc4_multiplier_seq
//   Iterative unsigned WIDTH x WIDTH shift-add multiplier (LC4 MUL unit).
//   Retires one multiplier bit per clock; a result appears WIDTH cycles
//   after the request is accepted, with no early-out.
// Ports
//   clk  single clock, all state changes on its rising edge
//   rst  asynchronous, active-high reset; aborts any operation in flight
//   bus  lc4_multiplier_seq_if.slave (request, operands, result, status)
module lc4_multiplier_seq #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    lc4_multiplier_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;        // captured multiplicand
    logic [WIDTH-1:0] b_q;        // multiplier; low product bits shift in from the top
    logic [WIDTH-1:0] acc_hi;     // upper half of the running product
    logic [CW-1:0]    count;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             ovf_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_hi_next;
    logic [WIDTH-1:0] b_next;
    logic             last_iter;

    // One iteration: conditional add into the upper half with the carry kept
    // in bit WIDTH, then shift {carry, acc_hi, b} right by one. The carry
    // becomes the new acc_hi MSB, so all-ones x all-ones stays exact.
    always_comb begin
        sum         = {1'b0, acc_hi} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        acc_hi_next = sum[WIDTH:1];
        b_next      = {sum[0], b_q[WIDTH-1:1]};
    end

    assign last_iter = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_hi  <= '0;
            count   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE, which gives
                // back-to-back operation every WIDTH+1 cycles.
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        state  <= RUN;
                        a_q    <= bus.i_multiplicand;
                        b_q    <= bus.i_multiplier;
                        acc_hi <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= acc_hi_next;
                    b_q    <= b_next;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        hi_q    <= acc_hi_next;
                        lo_q    <= b_next;
                        ovf_q   <= |acc_hi_next;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_product_lo = lo_q;
    assign bus.o_product_hi = hi_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.dbg_state    = state;
endmodule
